// File: rtl/cache_control_pkg.sv
// Shared types and encodings for the L1 cache controller.
// Holds the FSM state enum and the datapath mux select codes.
package cache_types_pkg;

   typedef enum logic [1:0] {S_HIT, S_WB, S_FILL} cache_state_t;

   localparam logic [1:0] ADDR_CPU  = 2'b00;
   localparam logic [1:0] ADDR_TAG0 = 2'b01;
   localparam logic [1:0] ADDR_TAG1 = 2'b10;

   localparam logic DIN_PMEM = 1'b0;
   localparam logic DIN_CPU  = 1'b1;

endpackage

// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath handshake bundle for the cache controller.
// master = controller side, slave = CPU/memory/datapath side.
interface cache_control_if;

   logic       mem_read;
   logic       mem_write;
   logic       mem_resp;
   logic       pmem_read;
   logic       pmem_write;
   logic       pmem_resp;
   logic       hit0;
   logic       hit1;
   logic       dirty0;
   logic       dirty1;
   logic       lru_out;
   logic       load_valid0;
   logic       load_valid1;
   logic       load_dirty0;
   logic       load_dirty1;
   logic       load_tag0;
   logic       load_tag1;
   logic       load_data0;
   logic       load_data1;
   logic       load_lru;
   logic [1:0] addr_sel;
   logic       datain_sel;

   modport master (
      input  mem_read, mem_write, pmem_resp, hit0, hit1, dirty0, dirty1, lru_out,
      output mem_resp, pmem_read, pmem_write,
      output load_valid0, load_valid1, load_dirty0, load_dirty1,
      output load_tag0, load_tag1, load_data0, load_data1, load_lru,
      output addr_sel, datain_sel
   );

   modport slave (
      output mem_read, mem_write, pmem_resp, hit0, hit1, dirty0, dirty1, lru_out,
      input  mem_resp, pmem_read, pmem_write,
      input  load_valid0, load_valid1, load_dirty0, load_dirty1,
      input  load_tag0, load_tag1, load_data0, load_data1, load_lru,
      input  addr_sel, datain_sel
   );

endinterface

// File: rtl/cache_perf_counter.sv
// Saturating event counter with synchronous active-high reset.
module cache_perf_counter #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set write-back L1 cache: hit handling, write-back,
// line fill and saturating hit/miss/write-back counters.
module cache_control
   import cache_types_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   cache_control_if.master      bus,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   cache_state_t state_q, state_d;

   logic req;
   logic live;
   logic victim_dirty;
   logic hit_inc, miss_inc, wb_inc;

   assign req          = bus.mem_read | bus.mem_write;
   assign victim_dirty = bus.lru_out ? bus.dirty1 : bus.dirty0;
   // Loads and completion are suppressed while reset is held so no partial line is committed.
   assign live         = ~rst;

   always_comb begin
      state_d         = state_q;
      hit_inc         = 1'b0;
      miss_inc        = 1'b0;
      wb_inc          = 1'b0;
      bus.mem_resp    = 1'b0;
      bus.pmem_read   = 1'b0;
      bus.pmem_write  = 1'b0;
      bus.load_valid0 = 1'b0;
      bus.load_valid1 = 1'b0;
      bus.load_dirty0 = 1'b0;
      bus.load_dirty1 = 1'b0;
      bus.load_tag0   = 1'b0;
      bus.load_tag1   = 1'b0;
      bus.load_data0  = 1'b0;
      bus.load_data1  = 1'b0;
      bus.load_lru    = 1'b0;
      bus.addr_sel    = ADDR_CPU;
      bus.datain_sel  = DIN_PMEM;

      unique case (state_q)
         S_HIT: begin
            if (req) begin
               if (bus.hit0 | bus.hit1) begin
                  bus.mem_resp = live;
                  bus.load_lru = live;
                  hit_inc      = 1'b1;
                  // A write (including read+write) merges CPU data into the hitting way.
                  if (bus.mem_write) begin
                     bus.datain_sel = DIN_CPU;
                     if (bus.hit0) begin
                        bus.load_data0  = live;
                        bus.load_dirty0 = live;
                     end else begin
                        bus.load_data1  = live;
                        bus.load_dirty1 = live;
                     end
                  end
               end else begin
                  miss_inc = 1'b1;
                  state_d  = victim_dirty ? S_WB : S_FILL;
               end
            end
         end

         S_WB: begin
            bus.pmem_write = 1'b1;
            bus.addr_sel   = bus.lru_out ? ADDR_TAG1 : ADDR_TAG0;
            if (bus.pmem_resp) begin
               wb_inc  = 1'b1;
               state_d = S_FILL;
            end
         end

         S_FILL: begin
            bus.pmem_read  = 1'b1;
            bus.addr_sel   = ADDR_CPU;
            bus.datain_sel = DIN_PMEM;
            if (bus.pmem_resp) begin
               if (bus.lru_out) begin
                  bus.load_data1  = live;
                  bus.load_tag1   = live;
                  bus.load_valid1 = live;
                  bus.load_dirty1 = live;
               end else begin
                  bus.load_data0  = live;
                  bus.load_tag0   = live;
                  bus.load_valid0 = live;
                  bus.load_dirty0 = live;
               end
               state_d = S_HIT;
            end
         end

         default: state_d = S_HIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HIT;
      end else begin
         state_q <= state_d;
      end
   end

   cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (hit_inc),
      .count_o (hit_count)
   );

   cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (miss_inc),
      .count_o (miss_count)
   );

   cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (wb_inc),
      .count_o (wb_count)
   );

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: a transaction-level cache model drives the datapath status
// inputs and predicts every cycle of each request; a CNT_WIDTH=4 copy checks saturation.
module tb_cache_control;
   import cache_types_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_control_if cif ();
   cache_control_if cif4 ();

   logic [31:0] hit_count, miss_count, wb_count;
   logic [3:0]  hc4, mc4, wc4;

   cache_control #(.CNT_WIDTH(32)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (cif.master),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
   );

   cache_control #(.CNT_WIDTH(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .bus        (cif4.master),
      .hit_count  (hc4),
      .miss_count (mc4),
      .wb_count   (wc4)
   );

   // Reference cache state: per way, per set.
   logic        m_valid [2][8];
   logic [23:0] m_tag   [2][8];
   logic        m_dirty [2][8];
   logic        m_lru   [8];
   logic [31:0] cur_addr;
   int unsigned exp_hits, exp_miss, exp_wbs;
   int          n_checks, n_fail;

   assign cif.hit0    = m_valid[0][cur_addr[7:5]] && (m_tag[0][cur_addr[7:5]] == cur_addr[31:8]);
   assign cif.hit1    = m_valid[1][cur_addr[7:5]] && (m_tag[1][cur_addr[7:5]] == cur_addr[31:8]);
   assign cif.dirty0  = m_dirty[0][cur_addr[7:5]];
   assign cif.dirty1  = m_dirty[1][cur_addr[7:5]];
   assign cif.lru_out = m_lru[cur_addr[7:5]];

   assign cif4.mem_read  = cif.mem_read;
   assign cif4.mem_write = cif.mem_write;
   assign cif4.pmem_resp = cif.pmem_resp;
   assign cif4.hit0      = cif.hit0;
   assign cif4.hit1      = cif.hit1;
   assign cif4.dirty0    = cif.dirty0;
   assign cif4.dirty1    = cif.dirty1;
   assign cif4.lru_out   = cif.lru_out;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic        exp_hit;
      logic        exp_wb;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] loads();
      return {cif.load_valid0, cif.load_valid1, cif.load_dirty0, cif.load_dirty1,
              cif.load_tag0, cif.load_tag1, cif.load_data0, cif.load_data1, cif.load_lru};
   endfunction

   function automatic logic [8:0] exp_loads(input bit fill, input bit hitw, input int way,
                                            input bit lru);
      logic [8:0] e;
      e = '0;
      if (fill) begin
         if (way == 0) {e[8], e[6], e[4], e[2]} = 4'hF;
         else          {e[7], e[5], e[3], e[1]} = 4'hF;
      end
      if (hitw) begin
         if (way == 0) {e[6], e[2]} = 2'b11;
         else          {e[5], e[1]} = 2'b11;
      end
      e[0] = lru;
      return e;
   endfunction

   function automatic logic [3:0] sat4(input int unsigned v);
      return (v > 15) ? 4'hF : v[3:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_loads"}, 32'(loads()), 32'd0);
      chk({nm, "_resp"}, 32'(cif.mem_resp), 32'd0);
      chk({nm, "_pmem_rd"}, 32'(cif.pmem_read), 32'd0);
      chk({nm, "_pmem_wr"}, 32'(cif.pmem_write), 32'd0);
      chk({nm, "_addr_sel"}, 32'(cif.addr_sel), 32'd0);
      chk({nm, "_din_sel"}, 32'(cif.datain_sel), 32'd0);
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_hit_cnt"}, hit_count, exp_hits);
      chk({nm, "_miss_cnt"}, miss_count, exp_miss);
      chk({nm, "_wb_cnt"}, wb_count, exp_wbs);
      chk({nm, "_hit_cnt4"}, 32'(hc4), 32'(sat4(exp_hits)));
      chk({nm, "_miss_cnt4"}, 32'(mc4), 32'(sat4(exp_miss)));
      chk({nm, "_wb_cnt4"}, 32'(wc4), 32'(sat4(exp_wbs)));
   endtask

   // One CPU request from issue to completion; called at posedge+1.
   task automatic do_req(input string nm, input logic [31:0] addr, input logic wr,
                         input int wb_lat, input int fill_lat, input bit drop,
                         output logic hit_first, output logic did_wb);
      int   s;
      int   w;
      int   v;
      bit   h0, h1, first, done;
      logic [23:0] tg;
      s         = int'(addr[7:5]);
      tg        = addr[31:8];
      first     = 1'b1;
      done      = 1'b0;
      hit_first = 1'b0;
      did_wb    = 1'b0;
      cur_addr  = addr;
      cif.mem_write = wr;
      cif.mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!done) begin
         #1;
         h0 = m_valid[0][s] && (m_tag[0][s] == tg);
         h1 = m_valid[1][s] && (m_tag[1][s] == tg);
         if (h0 || h1) begin
            w = h0 ? 0 : 1;
            chk({nm, "_hit_resp"}, 32'(cif.mem_resp), 32'd1);
            chk({nm, "_hit_pmem"}, {30'd0, cif.pmem_read, cif.pmem_write}, 32'd0);
            chk({nm, "_hit_loads"}, 32'(loads()), 32'(exp_loads(1'b0, wr, w, 1'b1)));
            chk({nm, "_hit_din"}, 32'(cif.datain_sel), 32'(wr));
            hit_first = first;
            tick();
            m_lru[s] = h0;
            if (wr) m_dirty[w][s] = 1'b1;
            exp_hits++;
            cif.mem_read  = 1'b0;
            cif.mem_write = 1'b0;
            done = 1'b1;
         end else begin
            chk({nm, "_miss_resp"}, 32'(cif.mem_resp), 32'd0);
            chk({nm, "_miss_pmem"}, {30'd0, cif.pmem_read, cif.pmem_write}, 32'd0);
            chk({nm, "_miss_loads"}, 32'(loads()), 32'd0);
            v = int'(m_lru[s]);
            tick();
            exp_miss++;
            if (drop) begin
               cif.mem_read  = 1'b0;
               cif.mem_write = 1'b0;
            end
            if (m_dirty[v][s]) begin
               did_wb = 1'b1;
               for (int k = 0; k < wb_lat; k++) begin
                  cif.pmem_resp = (k == wb_lat - 1);
                  #1;
                  chk({nm, "_wb_pmem"}, {30'd0, cif.pmem_read, cif.pmem_write}, 32'd1);
                  chk({nm, "_wb_addr_sel"}, 32'(cif.addr_sel), (v == 1) ? 32'd2 : 32'd1);
                  chk({nm, "_wb_loads"}, {22'd0, cif.mem_resp, loads()}, 32'd0);
                  tick();
               end
               cif.pmem_resp = 1'b0;
               exp_wbs++;
            end
            for (int k = 0; k < fill_lat; k++) begin
               cif.pmem_resp = (k == fill_lat - 1);
               #1;
               chk({nm, "_fill_pmem"}, {30'd0, cif.pmem_read, cif.pmem_write}, 32'd2);
               chk({nm, "_fill_sel"}, {29'd0, cif.addr_sel, cif.datain_sel}, 32'd0);
               chk({nm, "_fill_resp"}, 32'(cif.mem_resp), 32'd0);
               chk({nm, "_fill_loads"}, 32'(loads()),
                   32'(exp_loads(k == fill_lat - 1, 1'b0, v, 1'b0)));
               tick();
            end
            cif.pmem_resp = 1'b0;
            m_valid[v][s] = 1'b1;
            m_tag[v][s]   = tg;
            m_dirty[v][s] = 1'b0;
            first = 1'b0;
            if (drop) begin
               #1;
               chk_idle({nm, "_dropped"});
               done = 1'b1;
            end
         end
      end
      chk_cnt(nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[5];
      logic        hf, wbf;
      logic [31:0] a;

      vecs[0] = '{32'h0000_0040, 1'b0, 1'b0, 1'b0};  // cold miss, fill way0
      vecs[1] = '{32'h0000_0040, 1'b0, 1'b1, 1'b0};  // read hit
      vecs[2] = '{32'h0000_0040, 1'b1, 1'b1, 1'b0};  // write hit way0
      vecs[3] = '{32'h0000_0140, 1'b0, 1'b0, 1'b0};  // set 2 miss, clean way1
      vecs[4] = '{32'h0000_0240, 1'b0, 1'b0, 1'b1};  // set 2 miss, dirty way0 evicted

      n_checks = 0;
      n_fail   = 0;
      exp_hits = 0;
      exp_miss = 0;
      exp_wbs  = 0;
      for (int i = 0; i < 8; i++) begin
         m_lru[i] = 1'b0;
         for (int j = 0; j < 2; j++) begin
            m_valid[j][i] = 1'b0;
            m_tag[j][i]   = '0;
            m_dirty[j][i] = 1'b0;
         end
      end
      cur_addr      = '0;
      cif.mem_read  = 1'b0;
      cif.mem_write = 1'b0;
      cif.pmem_resp = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_idle("reset");
      chk_cnt("reset");

      foreach (vecs[i]) begin
         do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, 2, 3, 1'b0, hf, wbf);
         chk($sformatf("vec%0d_hit_first", i), 32'(hf), 32'(vecs[i].exp_hit));
         chk($sformatf("vec%0d_wb", i), 32'(wbf), 32'(vecs[i].exp_wb));
      end

      // Make both ways of set 3 dirty, then reset while writing back way0.
      do_req("prep0", {24'h10, 3'd3, 5'd0}, 1'b1, 1, 1, 1'b0, hf, wbf);
      do_req("prep1", {24'h11, 3'd3, 5'd0}, 1'b1, 1, 1, 1'b0, hf, wbf);
      cur_addr     = {24'h12, 3'd3, 5'd0};
      cif.mem_read = 1'b1;
      #1;
      chk("rstwb_miss_resp", 32'(cif.mem_resp), 32'd0);
      tick();
      chk("rstwb_pmem_wr", 32'(cif.pmem_write), 32'd1);
      chk("rstwb_addr_sel", 32'(cif.addr_sel), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstwb_rst_loads", {22'd0, cif.mem_resp, loads()}, 32'd0);
      tick();
      rst          = 1'b0;
      cif.mem_read = 1'b0;
      exp_hits     = 0;
      exp_miss     = 0;
      exp_wbs      = 0;
      #1;
      chk_idle("rstwb_after");
      chk_cnt("rstwb_after");

      // 20 hits on set 2: narrow counter must pin at 4'hF.
      for (int i = 0; i < 20; i++) begin
         do_req("sat", 32'h0000_0240, 1'b0, 1, 1, 1'b0, hf, wbf);
      end
      chk("sat_hc4_pinned", 32'(hc4), 32'hF);
      chk("sat_hit_count", hit_count, 32'd20);

      for (int i = 0; i < 150; i++) begin
         a = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         do_req($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)),
                $urandom_range(1, 3), $urandom_range(1, 3), 1'b0, hf, wbf);
      end

      // Request withdrawn mid-miss: sequence finishes, no completion.
      do_req("drop", {24'h7F, 3'd5, 5'd4}, 1'b0, 2, 2, 1'b1, hf, wbf);
      tick();
      chk_idle("drop_after");
      chk_cnt("drop_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
